bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Downstream consumer of the mod-M tick counter's single-cycle max_tick pulse.
- Uses each tick as a time base to run an mm:ss stopwatch in BCD, with start, stop and clear control.
- Outputs four BCD digits for the seven-segment display multiplexer, plus running and rollover status.

Parameters:
- DIV, 1: number of accepted tick pulses per one-second increment; legal range 1..1024.
- MIN_TENS_MAX, 5: highest value of the minutes-tens digit before rollover; legal range 0..9.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle enable pulse from the upstream mod-M counter's max_tick.
- start  input  1  synchronous request to run.
- stop  input  1  synchronous request to pause.
- clr  input  1  synchronous clear to 00:00 and IDLE.
- d0  output  4  seconds ones, BCD 0..9.
- d1  output  4  seconds tens, BCD 0..5.
- d2  output  4  minutes ones, BCD 0..9.
- d3  output  4  minutes tens, BCD 0..MIN_TENS_MAX.
- running  output  1  high while the FSM is in RUN.
- rollover  output  1  one-cycle pulse when the count wraps to 00:00.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; d0..d3=0; prescaler=0; running=0; rollover=0.
  - Deassertion is synchronised externally; the block holds state while reset=0.
- FSM states: IDLE, RUN, PAUSE. All transitions happen on the rising edge of clk.
  - IDLE: start -> RUN. stop is ignored.
  - RUN: stop -> PAUSE. start is ignored.
  - PAUSE: start -> RUN. Digits and prescaler are held.
  - clr, from any state -> IDLE; d0..d3=0; prescaler=0.
- Priority within one cycle: clr > stop > start.
  - start and stop together in IDLE or PAUSE -> no transition.
  - start and stop together in RUN -> PAUSE.
- Outputs: running is registered and equals (state==RUN).
- Prescaler:
  - Width is max(1, clog2(DIV)).
  - Advances only when state==RUN and tick==1 and clr==0.
  - At DIV-1 it wraps to 0 and issues an internal inc; otherwise it increments.
  - With DIV=1, every accepted tick is an inc.
- Tick acceptance edge cases:
  - A tick in the same cycle as a start that moves IDLE/PAUSE -> RUN is NOT counted.
  - A tick in the same cycle as a stop in RUN IS counted, because the state sampled is still RUN.
- Digit cascade on inc:
  - d0 increments. At 9 it goes to 0 and carries to d1.
  - d1 wraps 5 -> 0 and carries to d2.
  - d2 wraps 9 -> 0 and carries to d3.
  - d3 wraps MIN_TENS_MAX -> 0.
- Rollover:
  - When all four digits wrap in the same inc (default count 59:59 -> 00:00), rollover=1 for exactly the following cycle.
  - State stays RUN after rollover.
- Latency: digits and rollover update on the clk edge that samples the qualifying tick, so they are visible one cycle after the tick is presented.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- Ticks in IDLE or PAUSE are dropped, not queued.
- Mid-operation reset:
  - Reset asserted during RUN forces the reset values immediately, without waiting for a clock edge.
  - After deassertion the block is in IDLE and needs start to run.
- Digit values are always legal BCD; no illegal codes are reachable.

Test Plan:
- Reset, then start, then 12 ticks with DIV=1 -> d1:d0 = 1:2, d3=d2=0, running=1, rollover=0.
- Preload by ticking to 59:59, then 1 more tick -> d3..d0 = 0,0,0,0; rollover high for exactly 1 cycle; running stays 1.
- DIV=4: start, then 7 ticks -> d0=1, prescaler=3; stop, then 5 ticks -> d0 still 1; start, then 1 tick -> d0=2.
- clr, start and stop asserted together while RUN at 03:27 -> next cycle d=00:00, state IDLE, running=0.
- start and stop together from IDLE -> remains IDLE. Then a start coinciding with a tick -> RUN, d0 stays 0. The next tick -> d0=1.
- reset driven low asynchronously mid-cycle while RUN at 12:34 -> outputs go to 0 before the next clk edge. After reset returns high, 10 ticks without start -> digits remain 00:00.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// mm:ss BCD stopwatch driven by an upstream single-cycle tick pulse.
// IDLE/RUN/PAUSE control with clr > stop > start priority; all outputs registered.
module bcd_stopwatch #(
  parameter int unsigned DIV          = 1,
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       rollover
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic          w_accept;
  logic          w_pre_wrap;
  logic          w_inc;
  logic          w_c0;
  logic          w_c1;
  logic          w_c2;
  logic          w_c3;

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start && !stop) w_state_nxt = RUN;
        RUN:     if (stop)           w_state_nxt = PAUSE;
        PAUSE:   if (start && !stop) w_state_nxt = RUN;
        default:                     w_state_nxt = IDLE;
      endcase
    end
  end

  // The state sampled this cycle decides acceptance, so a stop+tick in RUN still counts.
  always_comb begin
    w_accept   = (r_state == RUN) && tick && !clr;
    w_pre_wrap = (r_pre == PW'(DIV - 1));
    w_inc      = w_accept && w_pre_wrap;
    w_c0       = (d0 == 4'd9);
    w_c1       = w_c0 && (d1 == 4'd5);
    w_c2       = w_c1 && (d2 == 4'd9);
    w_c3       = w_c2 && (d3 == 4'(MIN_TENS_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      running  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      running  <= (w_state_nxt == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (w_accept) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      rollover <= 1'b0;
    end else if (clr) begin
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= w_inc && w_c3;
      if (w_inc) begin
        d0 <= w_c0 ? 4'd0 : d0 + 4'd1;
        if (w_c0) d1 <= (d1 == 4'd5) ? 4'd0 : d1 + 4'd1;
        if (w_c1) d2 <= (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
        if (w_c2) d3 <= (d3 == 4'(MIN_TENS_MAX)) ? 4'd0 : d3 + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: DIV=1 and DIV=4 instances, expected
// outputs queued as each step is driven and compared after the clock edge.
module tb_bcd_stopwatch;

  logic clk;
  logic a_rst, a_tick, a_start, a_stop, a_clr;
  logic b_rst, b_tick, b_start, b_stop, b_clr;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic a_run, a_ro, b_run, b_ro;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    string       tag;
    bit          sel;
    logic [17:0] exp;
  } exp_t;

  exp_t sb[$];

  bcd_stopwatch #(.DIV(1), .MIN_TENS_MAX(5)) u_a (
    .clk(clk), .reset(a_rst), .tick(a_tick), .start(a_start), .stop(a_stop), .clr(a_clr),
    .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3), .running(a_run), .rollover(a_ro)
  );

  bcd_stopwatch #(.DIV(4), .MIN_TENS_MAX(5)) u_b (
    .clk(clk), .reset(b_rst), .tick(b_tick), .start(b_start), .stop(b_stop), .clr(b_clr),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3), .running(b_run), .rollover(b_ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input bit sel, input logic [15:0] d,
                          input logic run, input logic ro);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = {d, run, ro};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [17:0] obs;
    e   = sb.pop_front();
    obs = e.sel ? {b_d3, b_d2, b_d1, b_d0, b_run, b_ro}
                : {a_d3, a_d2, a_d1, a_d0, a_run, a_ro};
    n_tests++;
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (d3d2d1d0,running,rollover)", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input bit sel, input logic tk, input logic st, input logic sp, input logic cl);
    if (sel) begin
      b_tick = tk; b_start = st; b_stop = sp; b_clr = cl;
    end else begin
      a_tick = tk; a_start = st; a_stop = sp; a_clr = cl;
    end
    @(posedge clk);
    #1;
    a_tick = 0; a_start = 0; a_stop = 0; a_clr = 0;
    b_tick = 0; b_start = 0; b_stop = 0; b_clr = 0;
  endtask

  task automatic step(input bit sel, input logic tk, input logic st, input logic sp,
                      input logic cl, input string tag, input logic [15:0] d,
                      input logic run, input logic ro);
    push_exp(tag, sel, d, run, ro);
    cyc(sel, tk, st, sp, cl);
    check_out();
  endtask

  task automatic ticks(input bit sel, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(sel, 1, 0, 0, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    a_rst = 0; a_tick = 0; a_start = 0; a_stop = 0; a_clr = 0;
    b_rst = 0; b_tick = 0; b_start = 0; b_stop = 0; b_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_a", 0, 16'h0000, 0, 0); check_out();
    push_exp("reset_b", 1, 16'h0000, 0, 0); check_out();
    @(negedge clk);
    a_rst = 1; b_rst = 1;
    @(posedge clk);
    #1;

    // DIV=1: start, 12 ticks
    step(0, 0, 1, 0, 0, "start_a",      16'h0000, 1, 0);
    step(0, 1, 0, 0, 0, "first_tick",   16'h0001, 1, 0);
    ticks(0, 10);
    step(0, 1, 0, 0, 0, "twelve_ticks", 16'h0012, 1, 0);

    // run up to 59:59 (3599 ticks total) and wrap
    ticks(0, 3586);
    step(0, 1, 0, 0, 0, "at_5959",      16'h5959, 1, 0);
    step(0, 1, 0, 0, 0, "wrap_0000",    16'h0000, 1, 1);
    step(0, 0, 0, 0, 0, "rollover_end", 16'h0000, 1, 0);

    // 207 s -> 03:27, then clr+start+stop together
    ticks(0, 206);
    step(0, 1, 0, 0, 0, "at_0327",      16'h0327, 1, 0);
    step(0, 0, 1, 1, 1, "clr_all",      16'h0000, 0, 0);
    step(0, 1, 0, 0, 0, "idle_tick",    16'h0000, 0, 0);

    // start+stop from IDLE, start coinciding with tick, then one tick
    step(0, 0, 1, 1, 0, "idle_ss",      16'h0000, 0, 0);
    step(0, 1, 1, 0, 0, "start_tick",   16'h0000, 1, 0);
    step(0, 1, 0, 0, 0, "tick_after",   16'h0001, 1, 0);

    // stop+tick in RUN counts; pause drops ticks; start+stop in RUN pauses
    step(0, 1, 0, 1, 0, "stop_tick",    16'h0002, 0, 0);
    step(0, 1, 0, 0, 0, "pause_tick",   16'h0002, 0, 0);
    step(0, 0, 1, 1, 0, "pause_ss",     16'h0002, 0, 0);
    step(0, 0, 1, 0, 0, "resume",       16'h0002, 1, 0);
    step(0, 0, 1, 1, 0, "run_ss",       16'h0002, 0, 0);

    // 12:34 = 754 s, then asynchronous reset mid-cycle
    step(0, 0, 0, 0, 1, "clr2",         16'h0000, 0, 0);
    step(0, 0, 1, 0, 0, "start2",       16'h0000, 1, 0);
    ticks(0, 753);
    step(0, 1, 0, 0, 0, "at_1234",      16'h1234, 1, 0);
    #2;
    a_rst = 0;
    #1;
    push_exp("async_reset", 0, 16'h0000, 0, 0); check_out();
    @(posedge clk);
    #1;
    push_exp("reset_held", 0, 16'h0000, 0, 0); check_out();
    @(negedge clk);
    a_rst = 1;
    ticks(0, 9);
    step(0, 1, 0, 0, 0, "post_reset_ticks", 16'h0000, 0, 0);

    // DIV=4 prescaler
    step(1, 0, 1, 0, 0, "b_start",      16'h0000, 1, 0);
    ticks(1, 3);
    step(1, 1, 0, 0, 0, "b_tick4",      16'h0001, 1, 0);
    ticks(1, 3);
    push_exp("b_tick7", 1, 16'h0001, 1, 0); check_out();
    step(1, 0, 0, 1, 0, "b_stop",       16'h0001, 0, 0);
    ticks(1, 4);
    step(1, 1, 0, 0, 0, "b_pause5",     16'h0001, 0, 0);
    step(1, 0, 1, 0, 0, "b_restart",    16'h0001, 1, 0);
    step(1, 1, 0, 0, 0, "b_prescale3",  16'h0002, 1, 0);
    ticks(1, 3);
    step(1, 1, 0, 0, 0, "b_next4",      16'h0003, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
